// File: rtl/hdu_pkg.sv
// Shared definitions for the hazard-detection-unit bank scheduler:
// lane count, scheduler state and the bank-select helper.
package hdu_pkg;

    localparam int PORTS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // The bank is the low bank_w bits of the address.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_w);
        return addr & ((32'd1 << bank_w) - 32'd1);
    endfunction

endpackage

// File: rtl/hdu_bank_grant.sv
// Combinational rotating-priority grant: at most one pending lane per bank,
// scanning lanes rr, rr+1, ... so the first pending lane is always granted.
module hdu_bank_grant
    import hdu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int BANK_W = 5
) (
    input  logic [PORTS*ADDR_W-1:0] addr,
    input  logic [PORTS-1:0]        pending,
    input  logic [2:0]              rr,
    output logic [PORTS-1:0]        grant
);

    logic [31:0] bank [PORTS];
    logic [2:0]  idx;
    logic        blocked;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            bank[i] = bank_of(32'(addr[i*ADDR_W +: ADDR_W]), BANK_W);
        end
    end

    always_comb begin
        grant   = '0;
        idx     = '0;
        blocked = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            idx     = rr + 3'(k);
            blocked = 1'b0;
            // A lane loses only to an earlier-scanned lane already holding its bank.
            for (int m = 0; m < PORTS; m++) begin
                if (grant[m] && (bank[m] == bank[idx])) begin
                    blocked = 1'b1;
                end
            end
            if (pending[idx] && !blocked) begin
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdu_bank_scheduler.sv
// Batch front end for the banked hazard unit: issues up to 8 lane addresses
// over as many cycles as bank conflicts require, freezing while stalled.
module hdu_bank_scheduler #(
    parameter int ADDR_W = 16,
    parameter int BANK_W = 5,
    parameter int PORTS  = hdu_pkg::PORTS,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PORTS*ADDR_W-1:0] in_addr,
    input  logic [PORTS-1:0]        in_mask,
    input  logic                    hdu_stall,
    output logic [PORTS*ADDR_W-1:0] out_raddr,
    output logic [PORTS-1:0]        out_rvalid,
    output logic                    batch_done,
    output logic [CNT_W-1:0]        conflict_cnt,
    output logic [CNT_W-1:0]        stall_cnt
);

    import hdu_pkg::state_t;
    import hdu_pkg::IDLE;
    import hdu_pkg::DRAIN;

    if (PORTS != 8) begin : g_ports_check
        $error("hdu_bank_scheduler supports exactly 8 lanes");
    end

    state_t                  state;
    logic [PORTS*ADDR_W-1:0] addr_q;
    logic [PORTS-1:0]        pending;
    logic [PORTS-1:0]        grant;
    logic [PORTS-1:0]        remain;
    logic [2:0]              rr;

    hdu_bank_grant #(
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_grant (
        .addr    (addr_q),
        .pending (pending),
        .rr      (rr),
        .grant   (grant)
    );

    assign remain   = pending & ~grant;
    assign in_ready = (state == IDLE);

    // Handshake: a batch is taken on any edge where in_valid && in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            pending      <= '0;
            rr           <= '0;
            out_rvalid   <= '0;
            out_raddr    <= '0;
            batch_done   <= 1'b0;
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            batch_done <= 1'b0;
            case (state)
                IDLE: begin
                    out_rvalid <= '0;
                    if (in_valid) begin
                        addr_q  <= in_addr;
                        pending <= in_mask;
                        if (in_mask != '0) begin
                            state <= DRAIN;
                        end else begin
                            batch_done <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (hdu_stall) begin
                        // Frozen: address bus keeps its last value, only valid drops.
                        out_rvalid <= '0;
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + CNT_W'(1);
                        end
                    end else begin
                        out_rvalid <= grant;
                        for (int j = 0; j < PORTS; j++) begin
                            out_raddr[j*ADDR_W +: ADDR_W] <= grant[j] ? addr_q[j*ADDR_W +: ADDR_W] : '0;
                        end
                        pending <= remain;
                        rr      <= rr + 3'd1;
                        if (remain == '0) begin
                            batch_done <= 1'b1;
                            state      <= IDLE;
                        end else if (conflict_cnt != '1) begin
                            conflict_cnt <= conflict_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdu_bank_scheduler.sv
// Self-checking bench for hdu_bank_scheduler: directed scenarios plus a
// randomized run, all checked against a lane/bank-level reference model.
module tb_hdu_bank_scheduler;

    localparam int ADDR_W = 16;
    localparam int BANK_W = 5;
    localparam int PORTS  = 8;
    localparam int CNT_W  = 32;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [PORTS*ADDR_W-1:0] in_addr;
    logic [PORTS-1:0]        in_mask;
    logic                    hdu_stall;
    logic [PORTS*ADDR_W-1:0] out_raddr;
    logic [PORTS-1:0]        out_rvalid;
    logic                    batch_done;
    logic [CNT_W-1:0]        conflict_cnt;
    logic [CNT_W-1:0]        stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] exp_q[$];
    bit                sb_on = 0;

    hdu_bank_scheduler #(
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W),
        .PORTS  (PORTS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_mask      (in_mask),
        .hdu_stall    (hdu_stall),
        .out_raddr    (out_raddr),
        .out_rvalid   (out_rvalid),
        .batch_done   (batch_done),
        .conflict_cnt (conflict_cnt),
        .stall_cnt    (stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: lanes waiting to go out, a rotating start lane, and
    // per cycle a set of banks already used.
    bit                      m_busy;
    logic [PORTS-1:0]        m_pend;
    logic [ADDR_W-1:0]       m_addr [PORTS];
    int                      m_rr;
    logic [PORTS-1:0]        e_rvalid;
    logic [PORTS*ADDR_W-1:0] e_raddr;
    logic                    e_done;
    logic [CNT_W-1:0]        e_conf;
    logic [CNT_W-1:0]        e_stall;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   = 0;
            m_pend   = '0;
            m_rr     = 0;
            e_rvalid = '0;
            e_raddr  = '0;
            e_done   = 1'b0;
            e_conf   = '0;
            e_stall  = '0;
        end else begin
            e_done = 1'b0;
            if (!m_busy) begin
                e_rvalid = '0;
                if (in_valid) begin
                    for (int i = 0; i < PORTS; i++) m_addr[i] = in_addr[i*ADDR_W +: ADDR_W];
                    m_pend = in_mask;
                    if (in_mask != '0) m_busy = 1;
                    else e_done = 1'b1;
                end
            end else if (hdu_stall) begin
                e_rvalid = '0;
                if (e_stall != '1) e_stall = e_stall + 1;
            end else begin
                bit [31:0] used;
                used = '0;
                e_rvalid = '0;
                e_raddr  = '0;
                for (int k = 0; k < PORTS; k++) begin
                    int j;
                    int b;
                    j = (m_rr + k) % PORTS;
                    b = int'(m_addr[j]) % (1 << BANK_W);
                    if (m_pend[j] && !used[b]) begin
                        used[b] = 1'b1;
                        e_rvalid[j] = 1'b1;
                        e_raddr[j*ADDR_W +: ADDR_W] = m_addr[j];
                    end
                end
                m_pend = m_pend & ~e_rvalid;
                m_rr   = (m_rr + 1) % PORTS;
                if (m_pend == '0) begin
                    e_done = 1'b1;
                    m_busy = 0;
                end else if (e_conf != '1) begin
                    e_conf = e_conf + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        check("in_ready", 128'(in_ready), 128'(!m_busy));
        check("out_rvalid", 128'(out_rvalid), 128'(e_rvalid));
        check("out_raddr", 128'(out_raddr), 128'(e_raddr));
        check("batch_done", 128'(batch_done), 128'(e_done));
        check("conflict_cnt", 128'(conflict_cnt), 128'(e_conf));
        check("stall_cnt", 128'(stall_cnt), 128'(e_stall));
    endtask

    // one clock: inputs were set before the edge, outputs sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (sb_on) begin
            for (int j = 0; j < PORTS; j++) begin
                if (out_rvalid[j]) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra_lane", 128'(j), 128'(PORTS));
                    end else begin
                        check("sb_lane_addr", 128'(out_raddr[j*ADDR_W +: ADDR_W]), 128'(exp_q.pop_front()));
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        hdu_stall = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic set_addr(input int lane, input logic [ADDR_W-1:0] a);
        in_addr[lane*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic load_partial();
        set_addr(0, 16'h0003);
        set_addr(1, 16'h0023);
        for (int j = 2; j < PORTS; j++) set_addr(j, ADDR_W'(16'h0010 + j));
        in_mask = 8'hFF;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_addr = '0;
        in_mask = '0;
        hdu_stall = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_rvalid", 128'(out_rvalid), 128'(0));
        check("reset_counters", 128'({conflict_cnt, stall_cnt}), 128'(0));

        // no conflict: banks 0..7
        for (int j = 0; j < PORTS; j++) set_addr(j, ADDR_W'(j));
        in_mask = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("noconf_rvalid", 128'(out_rvalid), 128'(8'hFF));
        check("noconf_done", 128'(batch_done), 128'(1));
        check("noconf_lane5", 128'(out_raddr[5*ADDR_W +: ADDR_W]), 128'(5));
        check("noconf_cnt", 128'(conflict_cnt), 128'(0));

        // full conflict: every lane in bank 0, rotation yields one lane per cycle
        do_reset();
        for (int j = 0; j < PORTS; j++) set_addr(j, ADDR_W'(32 * (j + 1)));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            logic [7:0] onehot;
            onehot = 8'(1 << k);
            step();
            check("fullconf_rvalid", 128'(out_rvalid), 128'(onehot));
            check("fullconf_done", 128'(batch_done), 128'(k == PORTS - 1));
        end
        check("fullconf_cnt", 128'(conflict_cnt), 128'(7));

        // partial: lanes 0 and 1 share bank 3
        do_reset();
        load_partial();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("partial_first", 128'(out_rvalid), 128'(8'hFD));
        check("partial_first_done", 128'(batch_done), 128'(0));
        step();
        check("partial_second", 128'(out_rvalid), 128'(8'h02));
        check("partial_second_addr", 128'(out_raddr[1*ADDR_W +: ADDR_W]), 128'(16'h0023));
        check("partial_done", 128'(batch_done), 128'(1));

        // stall for three cycles inside a two-cycle batch
        do_reset();
        load_partial();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        hdu_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_rvalid", 128'(out_rvalid), 128'(0));
        end
        check("stall_cnt3", 128'(stall_cnt), 128'(3));
        hdu_stall = 1'b0;
        step();
        check("stall_after_first", 128'(out_rvalid), 128'(8'hFD));
        step();
        check("stall_after_second", 128'(out_rvalid), 128'(8'h02));
        check("stall_done_cycle5", 128'(batch_done), 128'(1));

        // empty mask
        do_reset();
        in_mask = 8'h00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("empty_done", 128'(batch_done), 128'(1));
        check("empty_rvalid", 128'(out_rvalid), 128'(0));
        check("empty_ready", 128'(in_ready), 128'(1));
        step();
        check("empty_done_once", 128'(batch_done), 128'(0));

        // reset in the middle of a draining batch
        for (int j = 0; j < PORTS; j++) set_addr(j, ADDR_W'(32 * (j + 1)));
        in_mask = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_rvalid", 128'(out_rvalid), 128'(0));
        check("midrst_ready", 128'(in_ready), 128'(1));
        check("midrst_counters", 128'({conflict_cnt, stall_cnt}), 128'(0));
        step();
        check("midrst_no_issue", 128'(out_rvalid), 128'(0));

        // back-to-back conflict-free batches with in_valid held high
        do_reset();
        exp_q.delete();
        for (int j = 0; j < PORTS; j++) exp_q.push_back(ADDR_W'(j));
        for (int j = 0; j < PORTS; j++) exp_q.push_back(ADDR_W'(16'h0140 + j));
        sb_on = 1;
        for (int j = 0; j < PORTS; j++) set_addr(j, ADDR_W'(j));
        in_mask = 8'hFF;
        in_valid = 1'b1;
        step();
        check("b2b_busy", 128'(in_ready), 128'(0));
        for (int j = 0; j < PORTS; j++) set_addr(j, ADDR_W'(16'h0140 + j));
        step();
        check("b2b_first_done", 128'(batch_done), 128'(1));
        check("b2b_ready_with_done", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        step();
        check("b2b_second_rvalid", 128'(out_rvalid), 128'(8'hFF));
        check("b2b_queue_empty", 128'(exp_q.size()), 128'(0));
        sb_on = 0;

        // randomized traffic with bank-heavy addresses, stalls and rare resets
        do_reset();
        for (int c = 0; c < 800; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            hdu_stall = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 150) == 0);
            for (int j = 0; j < PORTS; j++) begin
                set_addr(j, ADDR_W'(($urandom_range(0, 15) << BANK_W) | $urandom_range(0, 5)));
            end
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
